// File: rtl/z16_seq_ctrl_if.sv
// Z16 sequencer bus bundle: instruction fetch, decoder feedback, branch, and data-memory handshake.
// master = sequencer side, slave = memories/decoder/ALU side.
interface z16_seq_ctrl_if;
  logic        o_imem_req;
  logic [15:0] o_imem_addr;
  logic        i_imem_ack;
  logic [15:0] i_imem_data;
  logic [15:0] o_instr;
  logic [3:0]  i_opecode;
  logic        i_rd_wen;
  logic        i_mem_wen;
  logic        i_mem_ren;
  logic        i_br_taken;
  logic [15:0] i_br_target;
  logic [15:0] o_pc;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic        i_dmem_ack;
  logic        o_rf_we;
  logic        o_alu_en;
  logic        o_halted;
  logic [2:0]  o_state;

  modport master (
    output o_imem_req, o_imem_addr, o_instr, o_pc, o_dmem_req, o_dmem_we,
           o_rf_we, o_alu_en, o_halted, o_state,
    input  i_imem_ack, i_imem_data, i_opecode, i_rd_wen, i_mem_wen, i_mem_ren,
           i_br_taken, i_br_target, i_dmem_ack
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_instr, o_pc, o_dmem_req, o_dmem_we,
           o_rf_we, o_alu_en, o_halted, o_state,
    output i_imem_ack, i_imem_data, i_opecode, i_rd_wen, i_mem_wen, i_mem_ren,
           i_br_taken, i_br_target, i_dmem_ack
  );
endinterface

// File: rtl/z16_seq_ctrl.sv
// Z16 multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with PC and instruction register.
// Optional retired-instruction counter enabled by macro Z16_SEQ_PERF_EN.
module z16_seq_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2,
  parameter logic [3:0]  HALT_OPC = 4'hF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  z16_seq_ctrl_if.master bus
`ifdef Z16_SEQ_PERF_EN
  ,
  output logic [31:0]    o_retired
`endif
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_RESET;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    bus.o_imem_req = 1'b0;
    bus.o_dmem_req = 1'b0;
    bus.o_dmem_we  = 1'b0;
    bus.o_rf_we    = 1'b0;
    bus.o_alu_en   = 1'b0;
    bus.o_halted   = 1'b0;
    unique case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        bus.o_imem_req = 1'b1;
        if (bus.i_imem_ack) begin
          instr_d = bus.i_imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = (bus.i_opecode == HALT_OPC) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        bus.o_alu_en = 1'b1;
        pc_d = bus.i_br_taken ? bus.i_br_target : pc_q + PC_STEP;
        if (bus.i_mem_wen || bus.i_mem_ren) begin
          state_d = ST_MEM;
        end else if (bus.i_rd_wen) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        // Write wins when both enables are set, so a write never writes back.
        bus.o_dmem_req = 1'b1;
        bus.o_dmem_we  = bus.i_mem_wen;
        if (bus.i_dmem_ack) begin
          state_d = (bus.i_rd_wen && !bus.i_mem_wen) ? ST_WB : ST_FETCH;
        end
      end
      ST_WB: begin
        bus.o_rf_we = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_HALT: bus.o_halted = 1'b1;
      default: state_d = ST_RESET;
    endcase
  end

  assign bus.o_imem_addr = pc_q;
  assign bus.o_pc        = pc_q;
  assign bus.o_instr     = instr_q;
  assign bus.o_state     = state_q;

`ifdef Z16_SEQ_PERF_EN
  logic [31:0] retired_q;
  logic        retire_now;

  // An instruction retires on any return to FETCH from its final state.
  assign retire_now = (state_d == ST_FETCH) &&
                      ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      retired_q <= 32'd0;
    end else if (retire_now) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign o_retired = retired_q;
`endif

endmodule

// File: tb/tb_z16_seq_ctrl.sv
// Self-checking bench for z16_seq_ctrl: directed scenarios plus randomized instruction stream
// against a transaction-level model of per-instruction state path, pulses and PC.
module tb_z16_seq_ctrl;
  localparam logic [2:0] S_RESET = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  z16_seq_ctrl_if bus();

  // Bench-side decoder: [15]=mem_ren, [14]=mem_wen, [12]=rd_wen, [11:8]=opcode.
  assign bus.i_opecode = bus.o_instr[11:8];
  assign bus.i_mem_ren = bus.o_instr[15];
  assign bus.i_mem_wen = bus.o_instr[14];
  assign bus.i_rd_wen  = bus.o_instr[12];

`ifdef Z16_SEQ_PERF_EN
  logic [31:0] retired;
  int exp_retired = 0;
  z16_seq_ctrl dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.master), .o_retired(retired));
`else
  z16_seq_ctrl dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.master));
`endif

  int n_cmp = 0;
  int n_mis = 0;
  logic [15:0] exp_pc = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_imem_ack  = 1'b0;
    bus.i_imem_data = 16'h0000;
    bus.i_dmem_ack  = 1'b0;
    bus.i_br_taken  = 1'b0;
    bus.i_br_target = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    check("rst_state",    32'(bus.o_state),    32'(S_RESET));
    check("rst_pc",       32'(bus.o_pc),       32'h0);
    check("rst_instr",    32'(bus.o_instr),    32'h0);
    check("rst_halted",   32'(bus.o_halted),   32'h0);
    check("rst_pulses",   32'({bus.o_imem_req, bus.o_dmem_req, bus.o_dmem_we, bus.o_rf_we, bus.o_alu_en}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_to_fetch", 32'(bus.o_state),    32'(S_FETCH));
    exp_pc = 16'h0000;
`ifdef Z16_SEQ_PERF_EN
    check("rst_retired",  retired, 32'h0);
    exp_retired = 0;
`endif
    $display("reset: state %0d pc %h", bus.o_state, bus.o_pc);
  endtask

  // Runs one instruction from FETCH to its next FETCH (or HALT) and checks it against the model.
  task automatic run_instr(input logic [15:0] instr, input int fd, input int dd,
                           input logic br, input logic [15:0] tgt, input bit noise);
    logic [15:0] pc0;
    logic [2:0]  st;
    logic [2:0]  exp_tr[$];
    logic [2:0]  got_tr[$];
    int n_rf, n_alu, n_dreq, n_dwe, mwait;
    bit done, halt, mem, wb, trace_ok;

    pc0  = exp_pc;
    halt = (instr[11:8] == 4'hF);
    mem  = !halt && (instr[15] || instr[14]);
    wb   = !halt && instr[12] && !instr[14];
    for (int k = 0; k <= fd; k++) exp_tr.push_back(S_FETCH);
    exp_tr.push_back(S_DECODE);
    if (!halt) exp_tr.push_back(S_EXEC);
    if (mem) for (int k = 0; k <= dd; k++) exp_tr.push_back(S_MEM);
    if (wb) exp_tr.push_back(S_WB);

    check("fetch_entry", 32'(bus.o_state), 32'(S_FETCH));
    for (int k = 0; k <= fd; k++) begin
      check("imem_req",  32'(bus.o_imem_req),  32'h1);
      check("imem_addr", 32'(bus.o_imem_addr), 32'(pc0));
      got_tr.push_back(bus.o_state);
      bus.i_imem_ack  = (k == fd);
      bus.i_imem_data = (k == fd) ? instr : 16'($urandom);
      bus.i_dmem_ack  = noise ? 1'($urandom) : 1'b0;
      bus.i_br_taken  = noise ? 1'($urandom) : 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    bus.i_imem_ack = 1'b0;

    n_rf = 0; n_alu = 0; n_dreq = 0; n_dwe = 0; mwait = 0; done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      st = bus.o_state;
      if (st == S_FETCH || st == S_HALT) begin
        done = 1'b1;
      end else begin
        got_tr.push_back(st);
        n_rf  += int'(bus.o_rf_we);
        n_alu += int'(bus.o_alu_en);
        if (bus.o_dmem_req) begin
          n_dreq++;
          if (bus.o_dmem_we) n_dwe++;
        end
        bus.i_br_taken  = (st == S_EXEC) ? br  : (noise ? 1'($urandom) : 1'b0);
        bus.i_br_target = (st == S_EXEC) ? tgt : 16'($urandom);
        bus.i_imem_ack  = noise ? 1'($urandom) : 1'b0;
        bus.i_imem_data = 16'($urandom);
        if (st == S_MEM) begin
          bus.i_dmem_ack = (mwait == dd);
          mwait++;
        end else begin
          bus.i_dmem_ack = noise ? 1'($urandom) : 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
      end
    end
    clear_inputs();

    trace_ok = (got_tr.size() == exp_tr.size());
    if (trace_ok) foreach (exp_tr[i]) if (got_tr[i] !== exp_tr[i]) trace_ok = 1'b0;
    if (!halt) exp_pc = br ? tgt : pc0 + 16'd2;

    check("terminated",   32'(done), 32'h1);
    check("cycles",       32'(got_tr.size()), 32'(exp_tr.size()));
    check("state_trace",  32'(trace_ok), 32'h1);
    check("end_state",    32'(bus.o_state), halt ? 32'(S_HALT) : 32'(S_FETCH));
    check("instr_reg",    32'(bus.o_instr), 32'(instr));
    check("rf_we_pulses", 32'(n_rf), 32'(wb));
    check("alu_en_pulses", 32'(n_alu), halt ? 32'h0 : 32'h1);
    check("dmem_req_cyc", 32'(n_dreq), mem ? 32'(dd + 1) : 32'h0);
    check("dmem_we_cyc",  32'(n_dwe), (mem && instr[14]) ? 32'(dd + 1) : 32'h0);
    check("pc",           32'(bus.o_pc), 32'(exp_pc));
    check("halted",       32'(bus.o_halted), 32'(halt));
`ifdef Z16_SEQ_PERF_EN
    if (!halt) exp_retired++;
    check("retired", retired, 32'(exp_retired));
`endif
    $display("instr %h pc %h -> %h fd %0d dd %0d br %0d cycles %0d state %0d",
             instr, pc0, bus.o_pc, fd, dd, br, got_tr.size(), bus.o_state);
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // ALU op with write-back, single-cycle acks.
    run_instr(16'h3A10, 0, 0, 1'b0, 16'h0000, 1'b0);
    // Fetch ack delayed 5 cycles from PC 0.
    do_reset();
    run_instr(16'h3A10, 5, 0, 1'b0, 16'h0000, 1'b0);
    // Load with dmem ack delayed 3 cycles, then store.
    run_instr(16'h9120, 0, 3, 1'b0, 16'h0000, 1'b0);
    run_instr(16'h4230, 0, 0, 1'b0, 16'h0000, 1'b0);
    // Both mem enables with rd_wen: treated as a write, no write-back.
    run_instr(16'hD340, 0, 1, 1'b0, 16'h0000, 1'b0);
    // Branch to 0x0010, branch there to 0x0100, then wrap from 0xFFFE.
    run_instr(16'h3A10, 0, 0, 1'b1, 16'h0010, 1'b0);
    run_instr(16'h2B00, 0, 0, 1'b1, 16'h0100, 1'b0);
    run_instr(16'h2B00, 0, 0, 1'b1, 16'hFFFE, 1'b0);
    run_instr(16'h3A10, 0, 0, 1'b0, 16'h0000, 1'b0);
    run_instr(16'h2100, 0, 0, 1'b0, 16'h0000, 1'b0);

    // Halt: sticky, PC frozen, no requests despite stray acks.
    run_instr(16'h0F00, 1, 0, 1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 20; k++) begin
      bus.i_imem_ack = 1'($urandom);
      bus.i_dmem_ack = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("halt_reqs",   32'({bus.o_imem_req, bus.o_dmem_req}), 32'h0);
      check("halt_sticky", 32'(bus.o_halted), 32'h1);
      check("halt_pc",     32'(bus.o_pc), 32'(exp_pc));
    end
    $display("halt held 20 cycles at pc %h", bus.o_pc);
    clear_inputs();

    // Reset during FETCH with an ack pending: the ack must be dropped.
    do_reset();
    run_instr(16'h3A10, 0, 0, 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b0;
    bus.i_imem_ack  = 1'b1;
    bus.i_imem_data = 16'h3A10;
    @(posedge clk);
    @(negedge clk);
    check("midrst_state",  32'(bus.o_state),  32'(S_RESET));
    check("midrst_pc",     32'(bus.o_pc),     32'h0);
    check("midrst_instr",  32'(bus.o_instr),  32'h0);
    check("midrst_halted", 32'(bus.o_halted), 32'h0);
    rst_n = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    check("midrst_fetch", 32'(bus.o_state), 32'(S_FETCH));
    check("midrst_instr_kept", 32'(bus.o_instr), 32'h0);
    exp_pc = 16'h0000;
`ifdef Z16_SEQ_PERF_EN
    exp_retired = 0;
`endif
    $display("reset during fetch: state %0d pc %h", bus.o_state, bus.o_pc);

    // Three instructions then HALT (retired count ends at 3 when the counter exists).
    run_instr(16'h3A10, 0, 0, 1'b0, 16'h0000, 1'b0);
    run_instr(16'h9120, 0, 0, 1'b0, 16'h0000, 1'b0);
    run_instr(16'h4230, 0, 0, 1'b0, 16'h0000, 1'b0);
    run_instr(16'h0F00, 0, 0, 1'b0, 16'h0000, 1'b0);
`ifdef Z16_SEQ_PERF_EN
    check("retired_after_halt", retired, 32'd3);
`endif

    // Randomized stream with stray acks and random delays.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if (ins[11:8] == 4'hF) ins[11:8] = 4'h7;
      run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), 16'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
